// File: rtl/ls_unit.sv
// ls_unit: byte-serial load/store unit that issues one memory byte per cycle and broadcasts on the CDB.
// Latency: accept edge to CDB broadcast is N+2 cycles (loads), N+1 (stores), 1 (misaligned, checked build).
// Backpressure: LSreadEn is high only in IDLE; LSworkEn is ignored while busy.
// Ports: clk/rst, issue (LSworkEn, operandO, operandT, imm, wrtTag, wrtName, opCode, LSreadEn),
//        byte memory (memAddr, memRdEn, memWrEn, memWrData, memRdData),
//        CDB (enCDBwrt, CDBTag, CDBData, CDBName), lsExcept when LS_MISALIGN_CHECK_EN is defined.
// Optional feature macro: LS_MISALIGN_CHECK_EN (misaligned half/word accesses raise lsExcept instead of running).

`ifndef LS_UNIT_DEFS
`define LS_UNIT_DEFS
`define DataBus  [31:0]
`define TagBus   [3:0]
`define NameBus  [4:0]
`define OpBus    [2:0]
`define LB       3'd0
`define LH       3'd1
`define LW       3'd2
`define LBU      3'd3
`define LHU      3'd4
`define SB       3'd5
`define SH       3'd6
`define SW       3'd7
`define tagFree  4'd0
`define dataFree 32'd0
`define nameFree 5'd0
`endif

module ls_unit (
    input  logic            clk,
    input  logic            rst,
    input  logic            LSworkEn,
    input  logic `DataBus   operandO,
    input  logic `DataBus   operandT,
    input  logic `DataBus   imm,
    input  logic `TagBus    wrtTag,
    input  logic `NameBus   wrtName,
    input  logic `OpBus     opCode,
    output logic            LSreadEn,
    output logic [31:0]     memAddr,
    output logic            memRdEn,
    output logic            memWrEn,
    output logic [7:0]      memWrData,
    input  logic [7:0]      memRdData,
    output logic            enCDBwrt,
    output logic `TagBus    CDBTag,
    output logic `DataBus   CDBData,
    output logic `NameBus   CDBName
`ifdef LS_MISALIGN_CHECK_EN
    ,
    output logic            lsExcept
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WB = 2'd2} state_t;

    state_t          state;
    logic [31:0]     addr_q;
    logic [31:0]     sdata_q;
    logic [31:0]     rdata_q;
    logic `TagBus    tag_q;
    logic `NameBus   name_q;
    logic `OpBus     op_q;
    logic [2:0]      nbytes_q;
    logic [2:0]      cnt;        // edges elapsed since the accept edge
    logic            load_q;
    logic            mis_q;

    logic [31:0]     acc_addr;
    logic [2:0]      acc_n;
    logic            acc_load;
    logic            acc_mis;
    logic [2:0]      done_cnt;
    logic [2:0]      cap_idx;
    logic            cap_en;

    assign acc_addr = operandO + imm;

    always_comb begin
        acc_n    = 3'd4;
        acc_load = 1'b0;
        case (opCode)
            `LB, `LBU: begin acc_n = 3'd1; acc_load = 1'b1; end
            `LH, `LHU: begin acc_n = 3'd2; acc_load = 1'b1; end
            `LW:       begin acc_n = 3'd4; acc_load = 1'b1; end
            `SB:       acc_n = 3'd1;
            `SH:       acc_n = 3'd2;
            default:   acc_n = 3'd4;
        endcase
    end

`ifdef LS_MISALIGN_CHECK_EN
    assign acc_mis = ((acc_n == 3'd2) && acc_addr[0]) ||
                     ((acc_n == 3'd4) && (acc_addr[1:0] != 2'b00));
`else
    assign acc_mis = 1'b0;
`endif

    // Broadcast edge: loads need one edge after the last byte is captured,
    // stores one edge after the last strobe, misaligned ops go out immediately.
    always_comb begin
        if (mis_q)       done_cnt = 3'd1;
        else if (load_q) done_cnt = nbytes_q + 3'd2;
        else             done_cnt = nbytes_q + 3'd1;
    end

    // Read byte k is requested in the cycle after edge k and sampled at edge k+2.
    assign cap_idx = cnt - 3'd2;
    assign cap_en  = load_q && !mis_q && (cnt >= 3'd2) && (cap_idx < nbytes_q);

    function automatic logic [31:0] load_result(input logic `OpBus op, input logic [31:0] r);
        case (op)
            `LB:     load_result = {{24{r[7]}}, r[7:0]};
            `LBU:    load_result = {24'd0, r[7:0]};
            `LH:     load_result = {{16{r[15]}}, r[15:0]};
            `LHU:    load_result = {16'd0, r[15:0]};
            default: load_result = r;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            LSreadEn  <= 1'b1;
            memAddr   <= 32'd0;
            memRdEn   <= 1'b0;
            memWrEn   <= 1'b0;
            memWrData <= 8'd0;
            enCDBwrt  <= 1'b0;
            CDBTag    <= `tagFree;
            CDBData   <= `dataFree;
            CDBName   <= `nameFree;
            addr_q    <= 32'd0;
            sdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            tag_q     <= `tagFree;
            name_q    <= `nameFree;
            op_q      <= `LB;
            nbytes_q  <= 3'd0;
            cnt       <= 3'd0;
            load_q    <= 1'b0;
            mis_q     <= 1'b0;
`ifdef LS_MISALIGN_CHECK_EN
            lsExcept  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (LSworkEn) begin
                        addr_q   <= acc_addr;
                        sdata_q  <= operandT;
                        rdata_q  <= 32'd0;
                        tag_q    <= wrtTag;
                        name_q   <= wrtName;
                        op_q     <= opCode;
                        nbytes_q <= acc_n;
                        load_q   <= acc_load;
                        mis_q    <= acc_mis;
                        cnt      <= 3'd1;
                        LSreadEn <= 1'b0;
                        state    <= ACCESS;
                        // Byte 0 goes out in the cycle right after the accept edge.
                        if (!acc_mis) begin
                            memAddr   <= acc_addr;
                            memRdEn   <= acc_load;
                            memWrEn   <= !acc_load;
                            memWrData <= acc_load ? 8'd0 : operandT[7:0];
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 3'd1;
                    if (!mis_q && (cnt < nbytes_q)) begin
                        memAddr   <= addr_q + {29'd0, cnt};
                        memRdEn   <= load_q;
                        memWrEn   <= !load_q;
                        memWrData <= load_q ? 8'd0 : sdata_q[{cnt[1:0], 3'b000} +: 8];
                    end else begin
                        memAddr   <= 32'd0;
                        memRdEn   <= 1'b0;
                        memWrEn   <= 1'b0;
                        memWrData <= 8'd0;
                    end
                    if (cap_en) begin
                        rdata_q[{cap_idx[1:0], 3'b000} +: 8] <= memRdData;
                    end
                    if (cnt == done_cnt) begin
                        state    <= WB;
                        enCDBwrt <= 1'b1;
                        CDBTag   <= tag_q;
                        CDBName  <= name_q;
                        CDBData  <= (load_q && !mis_q) ? load_result(op_q, rdata_q) : 32'd0;
`ifdef LS_MISALIGN_CHECK_EN
                        lsExcept <= mis_q;
`endif
                    end
                end
                WB: begin
                    // WB coincides with the broadcast cycle; free the unit next.
                    state    <= IDLE;
                    LSreadEn <= 1'b1;
                    enCDBwrt <= 1'b0;
                    CDBTag   <= `tagFree;
                    CDBData  <= `dataFree;
                    CDBName  <= `nameFree;
`ifdef LS_MISALIGN_CHECK_EN
                    lsExcept <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ls_unit.sv
// tb_ls_unit: self-checking bench for ls_unit against a byte-memory reference model.
// Directed cases for the documented examples plus randomized loads/stores.
// Memory responder returns read data the cycle after each memRdEn.

`ifndef LS_UNIT_DEFS
`define LS_UNIT_DEFS
`define DataBus  [31:0]
`define TagBus   [3:0]
`define NameBus  [4:0]
`define OpBus    [2:0]
`define LB       3'd0
`define LH       3'd1
`define LW       3'd2
`define LBU      3'd3
`define LHU      3'd4
`define SB       3'd5
`define SH       3'd6
`define SW       3'd7
`define tagFree  4'd0
`define dataFree 32'd0
`define nameFree 5'd0
`endif

module tb_ls_unit;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            LSworkEn = 1'b0;
    logic [31:0]     operandO = 32'd0;
    logic [31:0]     operandT = 32'd0;
    logic [31:0]     imm = 32'd0;
    logic [3:0]      wrtTag = 4'd0;
    logic [4:0]      wrtName = 5'd0;
    logic [2:0]      opCode = 3'd0;
    logic            LSreadEn;
    logic [31:0]     memAddr;
    logic            memRdEn;
    logic            memWrEn;
    logic [7:0]      memWrData;
    logic [7:0]      memRdData;
    logic            enCDBwrt;
    logic [3:0]      CDBTag;
    logic [31:0]     CDBData;
    logic [4:0]      CDBName;
`ifdef LS_MISALIGN_CHECK_EN
    logic            lsExcept;
`endif

    ls_unit dut (
        .clk(clk), .rst(rst), .LSworkEn(LSworkEn),
        .operandO(operandO), .operandT(operandT), .imm(imm),
        .wrtTag(wrtTag), .wrtName(wrtName), .opCode(opCode),
        .LSreadEn(LSreadEn), .memAddr(memAddr), .memRdEn(memRdEn),
        .memWrEn(memWrEn), .memWrData(memWrData), .memRdData(memRdData),
        .enCDBwrt(enCDBwrt), .CDBTag(CDBTag), .CDBData(CDBData), .CDBName(CDBName)
`ifdef LS_MISALIGN_CHECK_EN
        , .lsExcept(lsExcept)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int          cyc;
        logic [3:0]  tag;
        logic [4:0]  name;
        logic [31:0] data;
        logic        exc;
    } cdb_t;

    cdb_t        cdb_q[$];
    logic [31:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [31:0] ra_q[$];
    logic [7:0]  mem [logic [31:0]];
    logic [7:0]  rd_pend;
    bit          rd_pend_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic bit is_ld(input logic [2:0] op);
        return op == `LB || op == `LH || op == `LW || op == `LBU || op == `LHU;
    endfunction

    function automatic int op_size(input logic [2:0] op);
        if (op == `LB || op == `LBU || op == `SB) return 1;
        if (op == `LH || op == `LHU || op == `SH) return 2;
        return 4;
    endfunction

    always @(posedge clk) cycle++;

    // Memory responder and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        memRdData = rd_pend_v ? rd_pend : 8'($urandom);
        rd_pend_v = (memRdEn === 1'b1);
        if (rd_pend_v) rd_pend = mem_rd(memAddr);
        if (mon_on) begin
            check("rd_wr_exclusive", {31'd0, memRdEn & memWrEn}, 32'd0);
            if (memWrEn) begin
                mem[memAddr] = memWrData;
                wa_q.push_back(memAddr);
                wd_q.push_back(memWrData);
            end
            if (memRdEn) ra_q.push_back(memAddr);
            if (!memRdEn && !memWrEn) begin
                check("idle_memAddr", memAddr, 32'd0);
                check("idle_memWrData", 32'(memWrData), 32'd0);
            end
            if (enCDBwrt) begin
                cdb_t r;
                r.cyc = cycle; r.tag = CDBTag; r.name = CDBName; r.data = CDBData;
`ifdef LS_MISALIGN_CHECK_EN
                r.exc = lsExcept;
`else
                r.exc = 1'b0;
`endif
                cdb_q.push_back(r);
            end else begin
                check("idle_CDBTag", 32'(CDBTag), 32'(`tagFree));
                check("idle_CDBData", CDBData, `dataFree);
                check("idle_CDBName", 32'(CDBName), 32'(`nameFree));
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (LSreadEn) return;
        end
        check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_obs();
        cdb_q.delete(); wa_q.delete(); wd_q.delete(); ra_q.delete();
    endtask

    // Issue one op, model its behaviour from the rules, compare bus traffic and broadcast.
    task automatic run_op(input logic [2:0] op, input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] wdata, input logic [3:0] tag, input logic [4:0] name);
        logic [31:0] a, v;
        logic [7:0]  b[4];
        int          n, lat, t0;
        bit          ld, mis;
        a   = base + off;
        n   = op_size(op);
        ld  = is_ld(op);
        mis = 1'b0;
`ifdef LS_MISALIGN_CHECK_EN
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
        v = 32'd0;
        for (int k = 0; k < 4; k++) b[k] = mem_rd(a + 32'(k));
        if (ld && !mis) begin
            for (int k = 0; k < n; k++) v = v | (32'(b[k]) << (8 * k));
            if ((op == `LB || op == `LH) && b[n-1][7]) v = v - (32'd1 << (8 * n));
        end
        lat = mis ? 1 : (ld ? n + 2 : n + 1);

        wait_ready();
        clear_obs();
        opCode = op; operandO = base; imm = off; operandT = wdata;
        wrtTag = tag; wrtName = name; LSworkEn = 1'b1;
        @(posedge clk); #1;
        LSworkEn = 1'b0;
        t0 = cycle;
        check("readEn_low_busy", 32'(LSreadEn), 32'd0);
        for (int i = 0; i < lat + 10; i++) begin
            @(negedge clk); #1;
            if (cdb_q.size() > 0) break;
        end
        if (cdb_q.size() == 0) begin
            check("cdb_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(cdb_q[0].cyc - t0), 32'(lat));
        check("cdb_tag", 32'(cdb_q[0].tag), 32'(tag));
        check("cdb_name", 32'(cdb_q[0].name), 32'(name));
        check("cdb_data", cdb_q[0].data, v);
`ifdef LS_MISALIGN_CHECK_EN
        check("lsExcept", 32'(cdb_q[0].exc), 32'(mis));
`endif
        @(negedge clk); #1;
        check("readEn_after_wb", 32'(LSreadEn), 32'd1);
        check("single_broadcast", 32'(cdb_q.size()), 32'd1);
        check("n_reads", 32'(ra_q.size()), (ld && !mis) ? 32'(n) : 32'd0);
        check("n_writes", 32'(wa_q.size()), (!ld && !mis) ? 32'(n) : 32'd0);
        for (int k = 0; k < n; k++) begin
            if (k < ra_q.size()) check("rd_addr", ra_q[k], a + 32'(k));
            if (k < wa_q.size()) begin
                check("wr_addr", wa_q[k], a + 32'(k));
                check("wr_data", 32'(wd_q[k]), 32'(wdata[8*k +: 8]));
            end
        end
    endtask

    initial begin
        int t0;
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_LSreadEn", 32'(LSreadEn), 32'd1);
        check("rst_enCDBwrt", 32'(enCDBwrt), 32'd0);
        check("rst_memRdEn", 32'(memRdEn), 32'd0);
        check("rst_memWrEn", 32'(memWrEn), 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        check("rst_memWrData", 32'(memWrData), 32'd0);
        check("rst_CDBTag", 32'(CDBTag), 32'(`tagFree));
        check("rst_CDBData", CDBData, `dataFree);
        check("rst_CDBName", 32'(CDBName), 32'(`nameFree));
`ifdef LS_MISALIGN_CHECK_EN
        check("rst_lsExcept", 32'(lsExcept), 32'd0);
`endif
        rst = 1'b0;
        mon_on = 1'b1;

        // Documented examples.
        mem[32'h104] = 8'h78; mem[32'h105] = 8'h56; mem[32'h106] = 8'h34; mem[32'h107] = 8'h12;
        run_op(`LW, 32'h100, 32'd4, 32'd0, 4'd3, 5'd9);
        run_op(`SH, 32'h200, 32'hFFFF_FFFE, 32'hDEADBEEF, 4'd4, 5'd10);
        mem[32'h300] = 8'h80;
        run_op(`LB, 32'h300, 32'd0, 32'd0, 4'd5, 5'd11);
        run_op(`LBU, 32'h300, 32'd0, 32'd0, 4'd6, 5'd12);
        run_op(`LW, 32'h100, 32'd2, 32'd0, 4'd7, 5'd13);            // addr 0x102
        run_op(`SW, 32'hFFFF_FFF0, 32'h10, 32'hCAFEF00D, 4'd8, 5'd14); // wraps to 0
        run_op(`LW, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd9, 5'd15);
        run_op(`LH, 32'h0, 32'd2, 32'd0, 4'd10, 5'd16);
        run_op(`LHU, 32'h0, 32'd2, 32'd0, 4'd11, 5'd17);
        run_op(`SB, 32'hFFFF_FFFF, 32'd0, 32'h000000AB, 4'd12, 5'd18);

        // LSworkEn held high across a busy LW: second op is taken only once LSreadEn returns.
        mem[32'h104] = 8'h78; mem[32'h105] = 8'h56; mem[32'h106] = 8'h34; mem[32'h107] = 8'h12;
        mem[32'h300] = 8'h80;
        wait_ready();
        clear_obs();
        opCode = `LW; operandO = 32'h100; imm = 32'd4; wrtTag = 4'd1; wrtName = 5'd2; LSworkEn = 1'b1;
        @(posedge clk); #1;
        t0 = cycle;
        opCode = `LBU; operandO = 32'h300; imm = 32'd0; wrtTag = 4'd13; wrtName = 5'd21;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (LSreadEn) break;
        end
        @(posedge clk); #1;
        LSworkEn = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (cdb_q.size() >= 2) break;
        end
        repeat (4) @(negedge clk);
        #1;
        check("b2b_count", 32'(cdb_q.size()), 32'd2);
        if (cdb_q.size() >= 2) begin
            check("b2b_lat0", 32'(cdb_q[0].cyc - t0), 32'd6);
            check("b2b_data0", cdb_q[0].data, 32'h12345678);
            check("b2b_tag0", 32'(cdb_q[0].tag), 32'd1);
            check("b2b_lat1", 32'(cdb_q[1].cyc - t0), 32'd11);
            check("b2b_data1", cdb_q[1].data, 32'h00000080);
            check("b2b_tag1", 32'(cdb_q[1].tag), 32'd13);
        end

        // Reset on the second ACCESS cycle of an SW.
        wait_ready();
        clear_obs();
        opCode = `SW; operandO = 32'h400; imm = 32'd0; operandT = 32'h11223344;
        wrtTag = 4'd2; wrtName = 5'd3; LSworkEn = 1'b1;
        @(posedge clk); #1;
        LSworkEn = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_memWrEn", 32'(memWrEn), 32'd0);
        check("midrst_LSreadEn", 32'(LSreadEn), 32'd1);
        rst = 1'b0;
        @(negedge clk); #1;
        check("postrst_LSreadEn", 32'(LSreadEn), 32'd1);
        repeat (10) @(negedge clk);
        #1;
        check("midrst_writes", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() >= 2) begin
            check("midrst_wa0", wa_q[0], 32'h400);
            check("midrst_wa1", wa_q[1], 32'h401);
        end
        check("midrst_no_cdb", 32'(cdb_q.size()), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] base;
            base = $urandom;
            if ($urandom_range(0, 1) == 0) base = base & 32'hFFFF_FFFC;
            run_op(3'($urandom_range(0, 7)), base, 32'($urandom_range(0, 64)) - 32'd32,
                   $urandom, 4'($urandom_range(1, 15)), 5'($urandom_range(1, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
